mult_div_unit: RTL
==================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/result width in bits.
REQ-002 SHALL have port: clk  input  1  clock; all state updates on the rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  request from control unit; sampled only in IDLE.
REQ-005 SHALL have port: op  input  2  operation: 00 mult (signed), 01 div (signed), 10/11 reserved.
REQ-006 SHALL have port: a  input  WIDTH  multiplicand or dividend (rs).
REQ-007 SHALL have port: b  input  WIDTH  multiplier or divisor (rt).
REQ-008 SHALL have port: busy  output  1  high in every state except IDLE.
REQ-009 SHALL have port: done  output  1  single-cycle pulse; hi/lo valid in the same cycle.
REQ-010 SHALL have port: hi  output  WIDTH  mult: product[63:32]; div: remainder.
REQ-011 SHALL have port: lo  output  WIDTH  mult: product[31:0]; div: quotient.
REQ-012 SHALL have port: div_zero  output  1  high together with done when a div had b == 0.

Function
REQ-013 SHALL implement FSM states IDLE, LOAD, RUN, FIX and DONE.
REQ-014 IDLE SHALL move to LOAD when start=1 and op is 00 or 01; a and b SHALL be captured in that cycle (accept cycle N).
REQ-015 start with op 10/11 SHALL be ignored: stay in IDLE, outputs unchanged.
REQ-016 start while busy=1 SHALL be ignored, and a and b SHALL not be re-sampled.
REQ-017 LOAD SHALL take 1 cycle; it stores operand magnitudes for div and clears the accumulator and iteration counter.
REQ-018 RUN SHALL take exactly 32 cycles, one iteration per cycle: radix-2 Booth for mult, restoring shift-subtract on magnitudes for div; the 5-bit counter exits RUN at 31.
REQ-019 FIX SHALL take 1 cycle; for div, quotient is negated if sign(a) XOR sign(b), and remainder takes the sign of a; for mult it is a pass-through.
REQ-020 DONE SHALL take 1 cycle with done=1, then return to IDLE.
REQ-021 done SHALL assert in cycle N+35 for every accepted operation except the div-by-zero path.
REQ-022 hi and lo SHALL update only on entry to DONE and hold until the next DONE or reset.
REQ-023 Division SHALL truncate toward zero.
REQ-024 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000 and hi=0 (wrap, no flag).
REQ-025 div_zero SHALL be 0 in all cycles except as defined in Configuration.

Reset
REQ-026 reset SHALL force IDLE, busy=0, done=0, div_zero=0, hi=0, lo=0 and counter=0 on the next edge.
REQ-027 reset mid-operation SHALL abort it, produce no done pulse, and leave the unit able to accept start the cycle after reset deasserts.
REQ-028 reset SHALL have priority over start in the same cycle.

Configuration
REQ-029 With macro MDU_DIVZERO_CHECK_EN defined, div with b == 0 in the accept cycle SHALL go IDLE->DONE directly: done=1 and div_zero=1 in cycle N+1, hi and lo unchanged.
REQ-030 Without MDU_DIVZERO_CHECK_EN, div_zero SHALL be tied 0 and b == 0 SHALL run the full 35-cycle path.
REQ-031 In that case results SHALL be a raw quotient magnitude of 0xFFFFFFFF and a remainder magnitude of |a|, then FIX sign rules.

Structure
REQ-032 Shared package mdu_pkg SHALL hold: op encodings (MDU_OP_MULT, MDU_OP_DIV), the FSM state enum, the WIDTH default and the iteration count constant 32.
REQ-033 The control unit SHALL import mdu_pkg op encodings rather than redefine them.
REQ-034 One sub-module, mdu_step, SHALL be combinational: one Booth/restoring iteration, selected by op.
REQ-035 The FSM, counter and registers SHALL remain in mult_div_unit.

Verification
REQ-036 mult a=7, b=0xFFFFFFFD (-3) -> done at N+35, hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-037 div a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1), div_zero=0.
REQ-038 div a=5, b=0 with MDU_DIVZERO_CHECK_EN -> done and div_zero at N+1, hi and lo keep prior values.
REQ-039 div a=5, b=0 without the macro -> done at N+35, lo=0xFFFFFFFF, hi=5.
REQ-040 mult 3*4 accepted, then start pulses at N+5 with a=9, and reset at N+10 -> no done pulse, hi=lo=0, busy=0.
REQ-041 REQ-040 follow-up: new mult 2*2 -> lo=4, hi=0.
REQ-042 div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-043 back-to-back: start held high continuously -> exactly one operation per 36 cycles, with done never high for two consecutive cycles.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states,
// default width and iteration count.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;
  localparam int MDU_ITERS = 32;

  localparam logic [1:0] MDU_OP_MULT = 2'b00;
  localparam logic [1:0] MDU_OP_DIV  = 2'b01;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    FIX,
    DONE
  } mdu_state_e;

endpackage

// File: rtl/mdu_step.sv
// One iteration of the iterative multiply/divide datapath: radix-2 Booth step
// for mult, restoring shift-subtract step on magnitudes for div.
module mdu_step
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic [1:0]       op,
  input  logic [WIDTH:0]   acc,
  input  logic [WIDTH-1:0] q,
  input  logic             q_m1,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH:0]   acc_nxt,
  output logic [WIDTH-1:0] q_nxt,
  output logic             q_m1_nxt
);

  logic [WIDTH:0] m_ext;
  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    m_ext    = {m[WIDTH-1], m};
    sum      = acc;
    shifted  = {acc[WIDTH-1:0], q[WIDTH-1]};
    diff     = shifted - {1'b0, m};
    acc_nxt  = acc;
    q_nxt    = q;
    q_m1_nxt = q_m1;
    if (op == MDU_OP_DIV) begin
      // Top bit of diff set means the trial subtraction went negative: restore.
      q_m1_nxt = 1'b0;
      if (!diff[WIDTH]) begin
        acc_nxt = diff;
        q_nxt   = {q[WIDTH-2:0], 1'b1};
      end else begin
        acc_nxt = shifted;
        q_nxt   = {q[WIDTH-2:0], 1'b0};
      end
    end else begin
      // acc carries one guard bit so adding/subtracting the most negative
      // multiplicand cannot overflow before the arithmetic shift.
      case ({q[0], q_m1})
        2'b01:   sum = acc + m_ext;
        2'b10:   sum = acc - m_ext;
        default: sum = acc;
      endcase
      acc_nxt  = {sum[WIDTH], sum[WIDTH:1]};
      q_nxt    = {sum[0], q[WIDTH-1:1]};
      q_m1_nxt = q[0];
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed multiply/divide unit (IDLE/LOAD/RUN/FIX/DONE, 36 cycles per op).
// Optional macro MDU_DIVZERO_CHECK_EN: divide by zero short-circuits to DONE and flags div_zero.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int CNT_W = $clog2(MDU_ITERS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MDU_ITERS - 1);

  // Handshake: start is honoured only in a cycle with busy=0 and a valid op
  // (a, b, op sampled on that edge); done then pulses for exactly one cycle with
  // hi/lo already valid, and busy drops in the following cycle.
  mdu_state_e state, state_nxt;

  logic [CNT_W-1:0] cnt;
  logic [1:0]       op_r;
  logic [WIDTH-1:0] a_r, b_r;
  logic [WIDTH:0]   acc_r;
  logic [WIDTH-1:0] q_r, m_r;
  logic             q_m1_r;

  logic [WIDTH:0]   acc_step;
  logic [WIDTH-1:0] q_step;
  logic             q_m1_step;

  logic             accept, skip_run, is_div;
  logic [WIDTH-1:0] a_mag, b_mag, fix_hi, fix_lo;

  assign accept = start && ((op == MDU_OP_MULT) || (op == MDU_OP_DIV));
`ifdef MDU_DIVZERO_CHECK_EN
  assign skip_run = accept && (op == MDU_OP_DIV) && (b == '0);
`else
  assign skip_run = 1'b0;
`endif

  assign is_div = (op_r == MDU_OP_DIV);
  assign a_mag  = a_r[WIDTH-1] ? -a_r : a_r;
  assign b_mag  = b_r[WIDTH-1] ? -b_r : b_r;
  // Quotient sign is the XOR of operand signs; remainder follows the dividend.
  assign fix_lo = (is_div && (a_r[WIDTH-1] ^ b_r[WIDTH-1])) ? -q_r : q_r;
  assign fix_hi = (is_div && a_r[WIDTH-1]) ? -acc_r[WIDTH-1:0] : acc_r[WIDTH-1:0];

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .op       (op_r),
    .acc      (acc_r),
    .q        (q_r),
    .q_m1     (q_m1_r),
    .m        (m_r),
    .acc_nxt  (acc_step),
    .q_nxt    (q_step),
    .q_m1_nxt (q_m1_step)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = skip_run ? DONE : LOAD;
      LOAD:    state_nxt = RUN;
      RUN:     if (cnt == CNT_LAST) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      op_r   <= MDU_OP_MULT;
      a_r    <= '0;
      b_r    <= '0;
      acc_r  <= '0;
      q_r    <= '0;
      m_r    <= '0;
      q_m1_r <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_r <= op;
            a_r  <= a;
            b_r  <= b;
          end
        end
        LOAD: begin
          acc_r  <= '0;
          cnt    <= '0;
          q_m1_r <= 1'b0;
          q_r    <= is_div ? a_mag : b_r;
          m_r    <= is_div ? b_mag : a_r;
        end
        RUN: begin
          acc_r  <= acc_step;
          q_r    <= q_step;
          q_m1_r <= q_m1_step;
          cnt    <= cnt + 1'b1;
        end
        FIX: begin
          hi <= fix_hi;
          lo <= fix_lo;
        end
        default: ;
      endcase
    end
  end

`ifdef MDU_DIVZERO_CHECK_EN
  logic dz_r;

  always_ff @(posedge clk) begin
    if (reset)              dz_r <= 1'b0;
    else if (state == IDLE) dz_r <= skip_run;
  end

  assign div_zero = (state == DONE) && dz_r;
`else
  assign div_zero = 1'b0;
`endif

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule
